// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART bridge: UART register map, status bit
// positions and the bridge FSM state type.
// Optional feature macro used by the bridge: UART_BRIDGE_RX_EN.
// ---------------------------------------------------------------------------
package uart_pkg;

  // UART register addresses on the 4-register slave port
  localparam logic [1:0] TXDATA = 2'd0;
  localparam logic [1:0] RXDATA = 2'd1;
  localparam logic [1:0] STATUS = 2'd2;
  localparam logic [1:0] DIV    = 2'd3;

  // Bit positions inside the UART status register
  localparam int TX_BUSY = 0;
  localparam int RX_FULL = 1;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_POLL,
    ST_PCAP,
    ST_TXWR,
    ST_RXRD,
    ST_RXCAP
  } bridge_state_e;

endpackage

// File: rtl/uart_bridge_if.sv
// ---------------------------------------------------------------------------
// uart_bridge_if
// Register bus between the bridge (master) and the UART register block
// (slave). Signal names are given from the bridge's point of view.
//   adr_o  : register address        dat_o : write data
//   sel_o  : byte selects            we_o  : write enable
//   stb_o  : strobe                  ack_i : acknowledge
//   dat_i  : read data, registered by the UART on the ack edge
// ---------------------------------------------------------------------------
interface uart_bridge_if;
  logic [1:0]  adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic        we_o;
  logic        stb_o;
  logic        ack_i;
  logic [31:0] dat_i;

  modport master (
    output adr_o, dat_o, sel_o, we_o, stb_o,
    input  ack_i, dat_i
  );

  modport slave (
    input  adr_o, dat_o, sel_o, we_o, stb_o,
    output ack_i, dat_i
  );
endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO. Full/empty come from an occupancy counter so every one
// of the DEPTH entries is usable. Pushes while full and pops while empty are
// ignored.
//   clk, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write side     pop_i/data_o : read side (data_o = head)
//   full_o, empty_o, level_o : status
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush, doPop;

  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; empty/full gate every access
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/uart_bridge.sv
// ---------------------------------------------------------------------------
// uart_bridge
// Bus master in front of the UART register block. Programs the baud divider
// after reset, then polls status forever: queued TX bytes are written when
// the transmitter is idle, received bytes are drained into an RX FIFO.
// Optional feature macro: UART_BRIDGE_RX_EN (RX FIFO and RX draining).
//   clk, rst_ni                 : clock, asynchronous active-low reset
//   tx_data_i/valid_i/ready_o   : byte stream into the TX FIFO
//   rx_data_o/valid_o/ready_i   : byte stream out of the RX FIFO
//   tx_level_o                  : TX FIFO occupancy
//   rx_overrun_o                : sticky, a received byte had to be skipped
//   bus                         : UART register bus (master side)
// ---------------------------------------------------------------------------
module uart_bridge
  import uart_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter logic [31:0] DIVIDER = 32'h00000018
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic [7:0]               tx_data_i,
  input  logic                     tx_valid_i,
  output logic                     tx_ready_o,
  output logic [7:0]               rx_data_o,
  output logic                     rx_valid_o,
  input  logic                     rx_ready_i,
  output logic [$clog2(DEPTH):0]   tx_level_o,
  output logic                     rx_overrun_o,
  uart_bridge_if.master            bus
);

  bridge_state_e state_q, state_d;
  logic [1:0]    adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          we_q, we_d;
  logic          stb_q, stb_d;

  logic          txPush, txPop, txFull, txEmpty;
  logic [7:0]    txHead;
  logic          unusedBits;

  assign bus.adr_o = adr_q;
  assign bus.dat_o = dat_q;
  assign bus.we_o  = we_q;
  assign bus.stb_o = stb_q;
  assign bus.sel_o = {4{stb_q}};

  // No TX bytes are accepted until the divider write has completed
  assign tx_ready_o = ~txFull & (state_q != ST_INIT);
  assign txPush     = tx_valid_i & tx_ready_o;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_txFifo (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .push_i  (txPush),
    .data_i  (tx_data_i),
    .pop_i   (txPop),
    .data_o  (txHead),
    .full_o  (txFull),
    .empty_o (txEmpty),
    .level_o (tx_level_o)
  );

`ifdef UART_BRIDGE_RX_EN
  logic                   rxPush, rxPop, rxFull, rxEmpty;
  logic                   overrun_q, overrun_d;
  logic [$clog2(DEPTH):0] rxLevel;

  assign rx_valid_o   = ~rxEmpty;
  assign rxPop        = rx_valid_o & rx_ready_i;
  assign rx_overrun_o = overrun_q;
  assign unusedBits   = ^{bus.dat_i[31:8], rxLevel};

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rxFifo (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .push_i  (rxPush),
    .data_i  (bus.dat_i[7:0]),
    .pop_i   (rxPop),
    .data_o  (rx_data_o),
    .full_o  (rxFull),
    .empty_o (rxEmpty),
    .level_o (rxLevel)
  );

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) overrun_q <= 1'b0;
    else         overrun_q <= overrun_d;
  end
`else
  assign rx_valid_o   = 1'b0;
  assign rx_data_o    = 8'h00;
  assign rx_overrun_o = 1'b0;
  assign unusedBits   = ^{bus.dat_i[31:2], rx_ready_i};
`endif

  // Bus outputs are registered, so a strobe appears the cycle after the
  // state that decided on it and drops on the edge that samples ack_i.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_INIT;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      stb_q   <= stb_d;
    end
  end

  // Next-state and bus set-up. In PCAP dat_i already holds the status word
  // because the UART registered it on the poll's ack edge. dat_q doubles as
  // the holding register for the popped TX byte.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    stb_d   = stb_q;
    txPop   = 1'b0;
`ifdef UART_BRIDGE_RX_EN
    rxPush    = 1'b0;
    overrun_d = overrun_q;
`endif
    case (state_q)
      ST_INIT: begin
        if (!stb_q) begin
          stb_d = 1'b1;
          we_d  = 1'b1;
          adr_d = DIV;
          dat_d = DIVIDER;
        end else if (bus.ack_i) begin
          stb_d   = 1'b0;
          we_d    = 1'b0;
          dat_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        stb_d   = 1'b1;
        we_d    = 1'b0;
        adr_d   = STATUS;
        dat_d   = '0;
        state_d = ST_POLL;
      end
      ST_POLL: begin
        if (bus.ack_i) begin
          stb_d   = 1'b0;
          state_d = ST_PCAP;
        end
      end
      ST_PCAP: begin
        state_d = ST_IDLE;
`ifdef UART_BRIDGE_RX_EN
        if (bus.dat_i[RX_FULL]) begin
          if (rxFull) begin
            overrun_d = 1'b1;
          end else begin
            stb_d   = 1'b1;
            we_d    = 1'b0;
            adr_d   = RXDATA;
            state_d = ST_RXRD;
          end
        end else
`endif
        if (!bus.dat_i[TX_BUSY] && !txEmpty) begin
          txPop   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          adr_d   = TXDATA;
          dat_d   = {24'h0, txHead};
          state_d = ST_TXWR;
        end
      end
      ST_TXWR: begin
        if (bus.ack_i) begin
          stb_d   = 1'b0;
          we_d    = 1'b0;
          dat_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_RXRD: begin
        if (bus.ack_i) begin
          stb_d   = 1'b0;
          state_d = ST_RXCAP;
        end
      end
      ST_RXCAP: begin
`ifdef UART_BRIDGE_RX_EN
        rxPush = 1'b1;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_uart_bridge.sv
// ---------------------------------------------------------------------------
// tb_uart_bridge
// Randomised bench for uart_bridge. A behavioural UART answers the bus
// (status from a busy-poll budget and a pending-RX queue, RX bytes from the
// same queue). Expected bus writes and RX bytes are queued when stimulus is
// issued; a negedge monitor checks every transfer and every RX pop.
// Honours UART_BRIDGE_RX_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_uart_bridge;
  import uart_pkg::*;

  localparam int          DEPTH   = 8;
  localparam logic [31:0] DIVIDER = 32'h00000018;
`ifdef UART_BRIDGE_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_ni;
  logic [7:0]             tx_data_i;
  logic                   tx_valid_i;
  logic                   tx_ready_o;
  logic [7:0]             rx_data_o;
  logic                   rx_valid_o;
  logic                   rx_ready_i;
  logic [$clog2(DEPTH):0] tx_level_o;
  logic                   rx_overrun_o;

  uart_bridge_if bus();

  uart_bridge #(.DEPTH(DEPTH), .DIVIDER(DIVIDER)) dut (
    .clk          (clk),
    .rst_ni       (rst_ni),
    .tx_data_i    (tx_data_i),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .tx_level_o   (tx_level_o),
    .rx_overrun_o (rx_overrun_o),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Zero-wait UART: ack is the strobe itself
  assign bus.ack_i = bus.stb_o;

  int          checks = 0;
  int          passes = 0;
  logic [7:0]  txExpQ[$];
  logic [7:0]  rxExpQ[$];
  logic [7:0]  uartRxQ[$];
  int          rxReadExp = 0;
  int          pollCount = 0;
  int          busyUntil = 0;
  bit          rxFlagNoise = 1'b0;
  bit          divPending = 1'b1;
  bit          firstAfterReset = 1'b1;
  logic [31:0] lastStatus = '0;
  logic [31:0] noiseQ = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic reportFail(input string name, input logic [31:0] actual);
    checks++;
    $display("[TB] FAIL %s: got 0x%0h, expected no such event", name, actual);
  endtask

  // Status the UART reports: busy while the poll budget lasts, RX flag while
  // bytes wait (or random noise on the flag when RX draining is absent)
  function automatic logic [31:0] modelStatus(input logic [31:0] noise);
    logic rxBit, busyBit;
    rxBit   = (uartRxQ.size() != 0) || (rxFlagNoise && noise[1]);
    busyBit = (pollCount < busyUntil);
    return {noise[31:2], rxBit, busyBit};
  endfunction

  always @(posedge clk) noiseQ <= $urandom();

  // UART register model: read data is registered on the ack edge
  always @(posedge clk) begin
    if (bus.stb_o && bus.ack_i && !bus.we_o) begin
      if (bus.adr_o == STATUS) begin
        bus.dat_i  <= modelStatus(noiseQ);
        lastStatus <= modelStatus(noiseQ);
        pollCount  <= pollCount + 1;
      end else if (bus.adr_o == RXDATA) begin
        bus.dat_i <= {noiseQ[31:8], (uartRxQ.size() != 0) ? uartRxQ[0] : noiseQ[7:0]};
        if (uartRxQ.size() != 0) void'(uartRxQ.pop_front());
      end
    end
  end

  // Monitor: every strobe cycle is one transfer; every RX pop is one byte
  always @(negedge clk) begin
    if (rst_ni && bus.stb_o) begin
      if (firstAfterReset) begin
        checkOutput("first transfer we/adr", 32'({bus.we_o, bus.adr_o}), 32'({1'b1, DIV}));
        firstAfterReset = 1'b0;
      end
      if (bus.we_o && bus.adr_o == DIV) begin
        if (!divPending) reportFail("divider write unexpected", bus.dat_o);
        else begin
          checkOutput("divider data", bus.dat_o, DIVIDER);
          checkOutput("divider sel", 32'(bus.sel_o), 32'h0000000F);
          divPending = 1'b0;
        end
      end else if (bus.we_o && bus.adr_o == TXDATA) begin
        if (txExpQ.size() == 0) reportFail("tx write unexpected", bus.dat_o);
        else begin
          checkOutput("tx write data", bus.dat_o, {24'h0, txExpQ.pop_front()});
          checkOutput("tx write sel", 32'(bus.sel_o), 32'h0000000F);
          checkOutput("tx write after idle status",
                      32'(RX_EN ? (lastStatus[1:0] == 2'b00) : !lastStatus[0]), 32'd1);
        end
      end else if (!bus.we_o && bus.adr_o == STATUS) begin
        // plain poll, always legal
      end else if (!bus.we_o && bus.adr_o == RXDATA && RX_EN) begin
        if (rxReadExp == 0) reportFail("rx read unexpected", 32'(bus.adr_o));
        else rxReadExp--;
      end else begin
        reportFail("illegal transfer we/adr", 32'({bus.we_o, bus.adr_o}));
      end
    end
    if (rst_ni && rx_valid_o && rx_ready_i) begin
      if (rxExpQ.size() == 0) reportFail("rx pop unexpected", 32'(rx_data_o));
      else checkOutput("rx pop data", 32'(rx_data_o), 32'(rxExpQ.pop_front()));
    end
  end

  // Offer one byte to the TX FIFO and wait (bounded) until it is taken
  task automatic applyStimulus(input logic [7:0] b);
    int c;
    @(negedge clk);
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    for (c = 0; c < 3000 && !tx_ready_o; c++) @(negedge clk);
    if (!tx_ready_o) begin
      reportFail("tx push timeout", 32'(tx_level_o));
      tx_valid_i = 1'b0;
      return;
    end
    txExpQ.push_back(b);
    @(posedge clk);
    #1 tx_valid_i = 1'b0;
  endtask

  task automatic waitTxDrain();
    for (int c = 0; c < 3000 && (txExpQ.size() != 0 || tx_level_o != 0); c++) @(negedge clk);
    checkOutput("tx bytes written", 32'(txExpQ.size()), 32'd0);
    checkOutput("tx level empty", 32'(tx_level_o), 32'd0);
  endtask

  task automatic checkResetState();
    checkOutput("reset stb", 32'(bus.stb_o), 32'd0);
    checkOutput("reset we", 32'(bus.we_o), 32'd0);
    checkOutput("reset adr", 32'(bus.adr_o), 32'd0);
    checkOutput("reset dat", bus.dat_o, 32'd0);
    checkOutput("reset sel", 32'(bus.sel_o), 32'd0);
    checkOutput("reset tx_ready", 32'(tx_ready_o), 32'd0);
    checkOutput("reset tx_level", 32'(tx_level_o), 32'd0);
    checkOutput("reset rx_valid", 32'(rx_valid_o), 32'd0);
    checkOutput("reset rx_overrun", 32'(rx_overrun_o), 32'd0);
    if (!RX_EN) checkOutput("reset rx_data", 32'(rx_data_o), 32'd0);
  endtask

  task automatic waitInitDone();
    int start;
    for (int c = 0; c < 100 && divPending; c++) @(negedge clk);
    checkOutput("divider write seen", 32'(divPending), 32'd0);
    start = pollCount;
    for (int c = 0; c < 100 && pollCount < start + 2; c++) @(negedge clk);
    checkOutput("status polls running", 32'(pollCount >= start + 2), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL global timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] b;
    int         n;
    rst_ni     = 1'b0;
    tx_data_i  = '0;
    tx_valid_i = 1'b0;
    rx_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState();
    rst_ni = 1'b1;
    waitInitDone();

    // Single byte with an idle UART; level 1 right after the push
    applyStimulus(8'hA5);
    checkOutput("tx level after push", 32'(tx_level_o), 32'd1);
    waitTxDrain();

    // Transmitter busy for 10 polls: byte must stay queued
    busyUntil = pollCount + 10;
    b = 8'($urandom());
    applyStimulus(b);
    for (int c = 0; c < 500 && pollCount < busyUntil - 3; c++) @(negedge clk);
    checkOutput("tx held while busy level", 32'(tx_level_o), 32'd1);
    checkOutput("tx held while busy pending", 32'(txExpQ.size()), 32'd1);
    waitTxDrain();

    // Random bursts against random busy windows
    if (!RX_EN) begin
      rxFlagNoise = 1'b1;
      rx_ready_i  = 1'b1;
    end
    for (int r = 0; r < 4; r++) begin
      busyUntil = pollCount + int'($urandom_range(0, 3));
      n = int'($urandom_range(1, 5));
      for (int k = 0; k < n; k++) applyStimulus(8'($urandom()));
    end
    waitTxDrain();
    if (!RX_EN) begin
      checkOutput("rx_valid stays low", 32'(rx_valid_o), 32'd0);
      checkOutput("rx_overrun stays low", 32'(rx_overrun_o), 32'd0);
      rxFlagNoise = 1'b0;
      @(posedge clk); #2 rx_ready_i = 1'b0;
    end

`ifdef UART_BRIDGE_RX_EN
    // One received byte, then pop it
    uartRxQ.push_back(8'h3C); rxExpQ.push_back(8'h3C); rxReadExp++;
    for (int c = 0; c < 300 && !rx_valid_o; c++) @(negedge clk);
    checkOutput("rx valid after read", 32'(rx_valid_o), 32'd1);
    checkOutput("rx head data", 32'(rx_data_o), 32'h3C);
    @(posedge clk); #2 rx_ready_i = 1'b1;
    @(posedge clk); #2 rx_ready_i = 1'b0;
    @(negedge clk);
    checkOutput("rx valid after pop", 32'(rx_valid_o), 32'd0);

    // Fill the RX FIFO, then one more byte must be skipped and flagged
    for (int k = 0; k < DEPTH; k++) begin
      b = 8'($urandom());
      uartRxQ.push_back(b); rxExpQ.push_back(b); rxReadExp++;
    end
    for (int c = 0; c < 1000 && rxReadExp != 0; c++) @(negedge clk);
    checkOutput("rx fill reads done", 32'(rxReadExp), 32'd0);
    repeat (4) @(negedge clk);
    b = 8'($urandom());
    uartRxQ.push_back(b); rxExpQ.push_back(b);
    repeat (40) @(negedge clk);
    checkOutput("rx overrun set", 32'(rx_overrun_o), 32'd1);
    checkOutput("skipped byte stays in uart", 32'(uartRxQ.size()), 32'd1);
    rxReadExp++;
    @(posedge clk); #2 rx_ready_i = 1'b1;
    for (int c = 0; c < 1000 && (rxExpQ.size() != 0 || uartRxQ.size() != 0); c++) @(negedge clk);
    checkOutput("rx drained", 32'(rxExpQ.size()), 32'd0);
    checkOutput("rx overrun sticky", 32'(rx_overrun_o), 32'd1);

    // Mixed RX and TX traffic
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom());
      uartRxQ.push_back(b); rxExpQ.push_back(b); rxReadExp++;
      applyStimulus(8'($urandom()));
    end
    waitTxDrain();
    for (int c = 0; c < 1000 && rxExpQ.size() != 0; c++) @(negedge clk);
    checkOutput("mixed rx drained", 32'(rxExpQ.size()), 32'd0);
    @(posedge clk); #2 rx_ready_i = 1'b0;
`endif

    // TX FIFO full: DEPTH bytes fit, the next one is refused
    busyUntil = pollCount + 100000;
    for (int k = 0; k < DEPTH; k++) applyStimulus(8'($urandom()));
    @(negedge clk);
    checkOutput("tx_ready when full", 32'(tx_ready_o), 32'd0);
    checkOutput("tx level when full", 32'(tx_level_o), 32'(DEPTH));
    tx_data_i  = 8'($urandom());
    tx_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    tx_valid_i = 1'b0;
    checkOutput("tx level after refused push", 32'(tx_level_o), 32'(DEPTH));
    busyUntil = pollCount;
    waitTxDrain();

    // Reset in the middle of a TX write
    applyStimulus(8'($urandom()));
    for (int c = 0; c < 300 && !(bus.stb_o && bus.we_o && bus.adr_o == TXDATA); c++) @(negedge clk);
    checkOutput("tx write strobe seen", 32'(bus.stb_o && bus.we_o && bus.adr_o == TXDATA), 32'd1);
    #1 rst_ni = 1'b0;
    #1 checkOutput("stb drops on reset", 32'(bus.stb_o), 32'd0);
    firstAfterReset = 1'b1;
    divPending      = 1'b1;
    repeat (2) @(negedge clk);
    checkResetState();
    rst_ni = 1'b1;
    waitInitDone();
    repeat (30) @(negedge clk);
    checkOutput("no tx byte pending after reset", 32'(txExpQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
